reg_file_legv8: RTL
===================

// Module: reg_file_legv8
// PURPOSE
//  32-entry x 64-bit LEGv8 register file: 2 combinational read ports, 1 synchronous write port.
//  Sits directly upstream of the ALU datapath; read ports A/B drive the ALU operand inputs.
//  Write port is fed by the writeback path (ALU F, memory or PC+4).
//  Register ZERO_REG (X31/XZR) is hardwired to zero.
// PARAMETERS
//  DATA_WIDTH  64  width of each register and of all data ports
//  ADDR_WIDTH  5   register select width; depth = 2**ADDR_WIDTH
//  ZERO_REG    31  index of the hardwired-zero register; reads 0, writes discarded
// PORTS
//  clock    in   1           rising-edge clock
//  reset_n  in   1           asynchronous reset, active-low
//  SA       in   ADDR_WIDTH  read select, port A
//  SB       in   ADDR_WIDTH  read select, port B
//  DA       in   ADDR_WIDTH  write select
//  W        in   1           write enable, active-high
//  D        in   DATA_WIDTH  write data
//  A        out  DATA_WIDTH  read data, port A (combinational from SA)
//  B        out  DATA_WIDTH  read data, port B (combinational from SB)
// BEHAVIOUR
//  - One clock (clock). Reset is asynchronous and active-low (reset_n).
//  - Reset: reset_n low clears every register to 0 immediately, without waiting for a clock edge.
//    A and B read 0 while reset_n is low.
//  - W and D are ignored while reset_n is low.
//  - On the first rising edge after reset_n returns high, normal writes resume.
//  - Write: on a rising clock edge with reset_n=1, W=1 and DA!=ZERO_REG, reg[DA] <= D.
//    The new value is visible on A/B after the edge (1-cycle write latency).
//  - W=0: no register changes.
//  - DA==ZERO_REG: the write is silently discarded.
//  - Read: A = reg[SA] and B = reg[SB], combinational, 0-cycle latency.
//    SA==ZERO_REG or SB==ZERO_REG returns 0 regardless of storage.
//  - SA==SB is legal; both ports return the same value.
//  - Read and write to the same address in one cycle: see CONFIGURATION.
//    The stored result at the edge is D in every case.
//  - No X propagation: every storage element has a defined reset value.
//    Out-of-range addresses cannot occur, since depth = 2**ADDR_WIDTH.
// CONFIGURATION
//  Macro REGFILE_BYPASS_EN.
//  - Defined: write-through forwarding.
//    If W=1, DA!=ZERO_REG and SA==DA, then A = D in the same cycle; likewise B when SB==DA.
//    Removes the writeback-to-operand hazard for the ALU.
//    The ZERO_REG and reset rules take priority over bypass: reset or ZERO_REG read yields 0.
//  - Undefined: no forwarding. A/B show the old reg contents until the clock edge commits D.
// TESTING
//  1. Async reset: preload X5=64'hDEAD, drop reset_n mid-cycle with no clock edge.
//     -> A(SA=5)=0 immediately; after release, all 32 regs read 0.
//  2. Write/read: W=1, DA=3, D=64'h0123_4567_89AB_CDEF, clock edge.
//     -> SA=3 and SB=3 both give 64'h0123_4567_89AB_CDEF next cycle.
//  3. XZR: W=1, DA=31, D=64'hFFFF_FFFF_FFFF_FFFF, clock edge.
//     -> A(SA=31)=0; X0..X30 unchanged.
//  4. W=0: DA=7, D=64'h55, clock edge.
//     -> X7 keeps its previous value (0 after reset).
//  5. Same-cycle RAW: X9=64'h1 stored; W=1, DA=9, D=64'h2, SA=9 before the edge.
//     -> A=64'h2 with REGFILE_BYPASS_EN, A=64'h1 without; A=64'h2 after the edge in both builds.
//  6. Write during reset: reset_n=0, W=1, DA=4, D=64'hAA, clock edge, then release.
//     -> X4=0.

Source files
------------

// File: rtl/reg_file_legv8.sv
// 32 x 64-bit LEGv8 register file: two combinational read ports and one synchronous write port.
// X31 (ZERO_REG) is hardwired to zero. Reset is asynchronous and active-low.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_legv8 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] SA,
  input  logic [ADDR_WIDTH-1:0] SB,
  input  logic [ADDR_WIDTH-1:0] DA,
  input  logic                  W,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B
);

  localparam int unsigned           Depth    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [DATA_WIDTH-1:0] regs_d [Depth];
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] a_raw;
  logic [DATA_WIDTH-1:0] b_raw;

  // A write that will actually commit; writes to the zero register are dropped.
  assign wr_en = W && (DA != ZeroAddr);

  // Next-state: only the addressed entry changes on a qualifying write.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[DA] = D;
    end
  end

  // Storage with asynchronous clear; the zero register entry is never written and stays 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: zero register and reset force 0, taking priority over any forwarding.
  always_comb begin
    a_raw = regs_q[SA];
    b_raw = regs_q[SB];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight writeback so the ALU sees it in the same cycle.
    if (wr_en && (SA == DA)) begin
      a_raw = D;
    end
    if (wr_en && (SB == DA)) begin
      b_raw = D;
    end
`else
    // No forwarding: old contents stay visible until the edge commits D.
`endif
    A = (!reset_n || (SA == ZeroAddr)) ? '0 : a_raw;
    B = (!reset_n || (SB == ZeroAddr)) ? '0 : b_raw;
  end

endmodule
